// File: rtl/multiplication_seq.sv
// Sequential shift-and-add multiplier: Product = Multiplicand * Multiplier + Addend.
// One start request is processed over eight clock cycles, followed by a one-cycle done pulse.
module multiplication_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  Multiplicand,
   input  logic [7:0]  Multiplier,
   input  logic [7:0]  Addend,
   output logic        busy,
   output logic        done,
   output logic [15:0] Product
);

   localparam int unsigned OP_W  = 8;
   localparam int unsigned ACC_W = 16;
   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OP_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  count, count_n;
   logic [ACC_W-1:0]  acc, acc_n;
   logic [ACC_W-1:0]  mcand, mcand_n;
   logic [OP_W-1:0]   mplier, mplier_n;
   logic [ACC_W-1:0]  product_n;
   logic              busy_n, done_n;
   logic [ACC_W-1:0]  sum;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         Product <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         count   <= count_n;
         acc     <= acc_n;
         mcand   <= mcand_n;
         mplier  <= mplier_n;
         Product <= product_n;
         busy    <= busy_n;
         done    <= done_n;
      end
   end

   // Next-state and next-datapath logic
   always_comb begin
      state_n   = state;
      count_n   = count;
      acc_n     = acc;
      mcand_n   = mcand;
      mplier_n  = mplier;
      product_n = Product;
      busy_n    = busy;
      done_n    = 1'b0;
      sum       = acc + (mplier[0] ? mcand : '0);

      unique case (state)
         IDLE, DONE: begin
            // A request in DONE restarts immediately, giving back-to-back operation
            if (start) begin
               state_n  = CALC;
               acc_n    = ACC_W'(Addend);
               mcand_n  = ACC_W'(Multiplicand);
               mplier_n = Multiplier;
               count_n  = '0;
               busy_n   = 1'b1;
            end else begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end
         end
         CALC: begin
            acc_n    = sum;
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
            count_n  = CNT_W'(count + 1'b1);
            if (count == LAST_BIT) begin
               state_n   = DONE;
               product_n = sum;
               busy_n    = 1'b0;
               done_n    = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_multiplication_seq.sv
// Self-checking bench for multiplication_seq: vector table, corner-case sequences,
// random operands and division-reconstruction against an arithmetic reference.
module tb_multiplication_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  Multiplicand;
   logic [7:0]  Multiplier;
   logic [7:0]  Addend;
   logic        busy;
   logic        done;
   logic [15:0] Product;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_prod = 16'h0000;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  c;
      logic [15:0] res;
   } vec_t;

   vec_t vecs[8];

   multiplication_seq dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .Multiplicand (Multiplicand),
      .Multiplier   (Multiplier),
      .Addend       (Addend),
      .busy         (busy),
      .done         (done),
      .Product      (Product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic [15:0] ref_model(input int a, input int b, input int c);
      return 16'(a * b + c);
   endfunction

   // Wait for done, checking output invariants while the computation runs
   task automatic wait_done(input string name, output int n);
      n = 0;
      while (!done && n < 20) begin
         check({name, "_hold"}, Product, exp_prod);
         step();
         n++;
         check({name, "_excl"}, busy & done, 0);
      end
      check({name, "_seen"}, done, 1);
   endtask

   task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [15:0] exp);
      int n;
      Multiplicand = a;
      Multiplier   = b;
      Addend       = c;
      start        = 1'b1;
      step();
      start        = 1'b0;
      Multiplicand = 8'($urandom);
      Multiplier   = 8'($urandom);
      Addend       = 8'($urandom);
      check({name, "_busy"}, busy, 1);
      wait_done(name, n);
      check({name, "_lat"}, n, 8);
      check({name, "_prod"}, Product, exp);
      exp_prod = exp;
      step();
      check({name, "_pulse"}, done, 0);
      check({name, "_idle"}, busy, 0);
   endtask

   initial begin
      int n, n2, dones;
      logic [7:0] a, b, c, dd, dv;

      vecs[0] = '{a: 8'd11,  b: 8'd13,  c: 8'd7,   res: 16'h0096};
      vecs[1] = '{a: 8'd255, b: 8'd255, c: 8'd255, res: 16'hFF00};
      vecs[2] = '{a: 8'd0,   b: 8'd0,   c: 8'd0,   res: 16'h0000};
      vecs[3] = '{a: 8'd6,   b: 8'd7,   c: 8'd1,   res: 16'h002B};
      vecs[4] = '{a: 8'd3,   b: 8'd4,   c: 8'd2,   res: 16'h000E};
      vecs[5] = '{a: 8'd255, b: 8'd1,   c: 8'd0,   res: 16'h00FF};
      vecs[6] = '{a: 8'd128, b: 8'd128, c: 8'd1,   res: 16'h4001};
      vecs[7] = '{a: 8'd0,   b: 8'd200, c: 8'd255, res: 16'h00FF};

      // Reset with start held high at the same edges: start must be ignored
      rst = 1'b1; start = 1'b1;
      Multiplicand = 8'd9; Multiplier = 8'd9; Addend = 8'd9;
      step();
      step();
      rst = 1'b0; start = 1'b0;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_prod", Product, 16'h0000);
      step();
      check("reset_start_ignored", busy, 0);

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].res);

      // start re-asserted mid-computation with other operands is ignored
      Multiplicand = 8'd6; Multiplier = 8'd7; Addend = 8'd1; start = 1'b1;
      step();
      dones = 0; n = 0;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         start = (cyc == 3 || cyc == 5);
         Multiplicand = 8'd200; Multiplier = 8'd99; Addend = 8'd50;
         step();
         if (done) begin
            dones++;
            if (n == 0) begin
               n = cyc;
               check("restart_prod", Product, 16'h002B);
               exp_prod = 16'h002B;
            end
         end
      end
      check("restart_lat", n, 8);
      check("restart_single_done", dones, 1);
      check("restart_idle", busy, 0);

      // Reset in the middle of a computation aborts it without a done pulse
      Multiplicand = 8'd100; Multiplier = 8'd2; Addend = 8'd0; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_prod", Product, 16'h0000);
      exp_prod = 16'h0000;
      dones = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         step();
         if (done) dones++;
      end
      check("abort_no_done", dones, 0);
      run_op("after_abort", 8'd3, 8'd4, 8'd2, 16'h000E);

      // start held continuously: back-to-back results 9 cycles apart
      Multiplicand = 8'd2; Multiplier = 8'd3; Addend = 8'd1; start = 1'b1;
      step();
      Multiplicand = 8'd5; Multiplier = 8'd5; Addend = 8'd5;
      wait_done("b2b_first", n);
      check("b2b_first_lat", n, 8);
      check("b2b_first_prod", Product, 16'h0007);
      exp_prod = 16'h0007;
      n2 = 0;
      step();
      n2++;
      check("b2b_restart_busy", busy, 1);
      while (!done && n2 < 20) begin
         check("b2b_hold", Product, exp_prod);
         step();
         n2++;
      end
      start = 1'b0;
      check("b2b_gap", n2, 9);
      check("b2b_second_prod", Product, 16'h001E);
      exp_prod = 16'h001E;
      step();
      check("b2b_pulse", done, 0);
      check("b2b_idle", busy, 0);

      // Random operands against A*B+C
      for (int i = 0; i < 1000; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         c = 8'($urandom);
         run_op("rand", a, b, c, ref_model(a, b, c));
      end

      // Division reconstruction: Divisor*Quotient+Remainder == Dividend
      for (int d = 0; d < 256; d++) begin
         dd = 8'(d);
         for (int k = 0; k < 3; k++) begin
            dv = (k == 0) ? 8'd1 : (k == 1) ? 8'd255 : 8'($urandom_range(255, 1));
            run_op("div", dv, 8'(dd / dv), 8'(dd % dv), 16'(dd));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
